// File: rtl/fft_r2dif_iter.sv
// Iterative radix-2 DIF FFT: load N samples, one in-place butterfly per clock, unload in natural order.
// Latency: first bin valid LOG2N*N/2+1 edges after the last sample is accepted; one bin per cycle after that.
// Backpressure: in_ready only in LOAD; output registers hold while out_valid & !out_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_real/in_imag sample stream (n = 0..N-1);
//        out_valid/out_ready/out_real/out_imag/out_index/out_last bin stream (k = 0..N-1);
//        busy is high while computing or unloading.
module fft_r2dif_iter #(
  parameter int LOG2N  = 3,
  parameter int DATA_W = 32,
  parameter int TW_W   = 16,
  parameter int SCALE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last,
  output logic              busy
);

  localparam int N  = 1 << LOG2N;
  localparam int HN = N / 2;
  // Wide enough for a (DATA_W+1) x TW_W complex product sum plus rounding.
  localparam int AW = DATA_W + TW_W + 2;
  localparam logic signed [AW-1:0] RND = AW'(1) <<< (TW_W - 2);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t state, state_nxt;
  logic [LOG2N-1:0] cnt;    // sample index in LOAD, bin index in UNLOAD
  logic [LOG2N-2:0] bfly;
  logic [2:0]       stage;

  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];

  // Twiddle ROM, evaluated at elaboration: W^t = cos(2*pi*t/N) - j*sin(2*pi*t/N).
  function automatic logic signed [TW_W-1:0] tw_val(input int t, input bit is_im);
    real amp, ang, v;
    amp = real'((1 << (TW_W - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * real'(t) / real'(N);
    v   = is_im ? -$sin(ang) : $cos(ang);
    return TW_W'($rtoi($floor(v * amp + 0.5)));
  endfunction

  logic signed [TW_W-1:0] rom_re [HN];
  logic signed [TW_W-1:0] rom_im [HN];
  for (genvar g = 0; g < HN; g++) begin : g_rom
    localparam logic signed [TW_W-1:0] C_RE = tw_val(g, 1'b0);
    localparam logic signed [TW_W-1:0] C_IM = tw_val(g, 1'b1);
    assign rom_re[g] = C_RE;
    assign rom_im[g] = C_IM;
  end

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2N; k++) r[k] = v[LOG2N-1-k];
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] v);
    if (&v[AW-1:DATA_W-1] || ~|v[AW-1:DATA_W-1]) return v[DATA_W-1:0];
    else if (v[AW-1]) return {1'b1, {(DATA_W-1){1'b0}}};
    else return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // Butterfly addressing: i0 is b with a zero inserted at the span bit position.
  logic [LOG2N-1:0] span, jj, i0, i1, tw_idx, bfly_ext;
  always_comb begin
    bfly_ext = {1'b0, bfly};
    span     = LOG2N'(HN) >> stage;
    jj       = bfly_ext & (span - LOG2N'(1));
    i0       = ((bfly_ext - jj) << 1) + jj;
    i1       = i0 + span;
    tw_idx   = jj << stage;
  end

  logic signed [DATA_W-1:0] x0_re, x0_im, x1_re, x1_im;
  logic signed [DATA_W:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [AW-1:0]     dw_re, dw_im, cw_re, cw_im, rot_re, rot_im;
  logic signed [DATA_W-1:0] y0_re, y0_im, y1_re, y1_im;
  always_comb begin
    x0_re  = mem_re[i0];
    x0_im  = mem_im[i0];
    x1_re  = mem_re[i1];
    x1_im  = mem_im[i1];
    sum_re = (DATA_W+1)'(x0_re) + (DATA_W+1)'(x1_re);
    sum_im = (DATA_W+1)'(x0_im) + (DATA_W+1)'(x1_im);
    dif_re = (DATA_W+1)'(x0_re) - (DATA_W+1)'(x1_re);
    dif_im = (DATA_W+1)'(x0_im) - (DATA_W+1)'(x1_im);
    dw_re  = AW'(dif_re);
    dw_im  = AW'(dif_im);
    cw_re  = AW'(rom_re[tw_idx[LOG2N-2:0]]);
    cw_im  = AW'(rom_im[tw_idx[LOG2N-2:0]]);
    if (tw_idx == '0) begin
      rot_re = dw_re;
      rot_im = dw_im;
    end else if (tw_idx == LOG2N'(HN / 2)) begin
      // Multiply by -j exactly instead of going through the rounded ROM value.
      rot_re = dw_im;
      rot_im = -dw_re;
    end else begin
      rot_re = (dw_re * cw_re - dw_im * cw_im + RND) >>> (TW_W - 1);
      rot_im = (dw_re * cw_im + dw_im * cw_re + RND) >>> (TW_W - 1);
    end
    y0_re = sat(AW'(sum_re) >>> SCALE);
    y0_im = sat(AW'(sum_im) >>> SCALE);
    y1_re = sat(rot_re >>> SCALE);
    y1_im = sat(rot_im >>> SCALE);
  end

  logic load_hs, out_hs, last_bfly;
  logic [LOG2N-1:0] cnt_inc, rd_addr;
  always_comb begin
    load_hs   = (state == S_LOAD) && in_valid && in_ready;
    out_hs    = (state == S_UNLOAD) && out_valid && out_ready;
    last_bfly = (stage == 3'(LOG2N - 1)) && (&bfly);
    cnt_inc   = cnt + LOG2N'(1);
    // Before the first bin is presented fetch bin cnt; afterwards prefetch the next one.
    rd_addr   = bitrev(out_valid ? cnt_inc : cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (load_hs && (&cnt)) state_nxt = S_COMPUTE;
      S_COMPUTE: if (last_bfly) state_nxt = S_UNLOAD;
      S_UNLOAD:  if (out_hs && (&cnt)) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      cnt       <= '0;
      bfly      <= '0;
      stage     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_LOAD);
      case (state)
        S_LOAD: if (load_hs) cnt <= cnt_inc;
        S_COMPUTE: begin
          bfly <= bfly + (LOG2N-1)'(1);
          if (&bfly) stage <= last_bfly ? 3'd0 : stage + 3'd1;
        end
        S_UNLOAD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_index <= cnt;
            out_real  <= mem_re[rd_addr];
            out_imag  <= mem_im[rd_addr];
          end else if (out_ready) begin
            cnt <= cnt_inc;
            if (&cnt) begin
              out_valid <= 1'b0;
            end else begin
              out_index <= cnt_inc;
              out_real  <= mem_re[rd_addr];
              out_imag  <= mem_im[rd_addr];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample array carries no reset; its contents are rewritten by every frame.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      mem_re[cnt] <= in_real;
      mem_im[cnt] <= in_imag;
    end else if (state == S_COMPUTE) begin
      mem_re[i0] <= y0_re;
      mem_im[i0] <= y0_im;
      mem_re[i1] <= y1_re;
      mem_im[i1] <= y1_im;
    end
  end

  assign out_last = out_valid && (out_index == LOG2N'(N - 1));
  assign busy     = (state != S_LOAD);

endmodule

// File: doc/fft_r2dif_iter.md
Name: fft_r2dif_iter

Overview:
- Iterative, parametrised radix-2 decimation-in-frequency FFT engine; the sequential successor to the fixed 8-point combinational butterfly network.
- Accepts one frame of N = 2^LOG2N complex samples over a valid/ready stream and stores it in an internal in-place register array.
- Computes the transform with a single shared butterfly, one butterfly per clock.
- Streams results out in natural frequency order with a second valid/ready handshake.

Parameters:
- LOG2N, 3, log2 of FFT length N (legal 2..6).
- DATA_W, 32, width of signed two's-complement real/imag samples, in and out.
- TW_W, 16, signed twiddle width, Q1.(TW_W-1).
- SCALE, 0, 1 = arithmetic shift right by 1 after every stage (output = DFT/N); 0 = unscaled.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  engine accepts a sample (LOAD state only)
- in_real  in  DATA_W  sample real part, natural order n=0..N-1
- in_imag  in  DATA_W  sample imag part
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts the bin
- out_real  out  DATA_W  X[k] real part
- out_imag  out  DATA_W  X[k] imag part
- out_index  out  LOG2N  bin index k
- out_last  out  1  high with k = N-1
- busy  out  1  high in COMPUTE or UNLOAD

Behaviour:
- Reset (async, rst_n=0): state=LOAD, load/bin/stage counters=0, in_ready=0, out_valid=0, out_last=0, out_index=0, out_real/out_imag=0, busy=0. in_ready rises on the first clock edge after reset release. Array contents are don't-care.
- FSM: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD: in_ready=1. Each in_valid&in_ready edge writes mem[cnt] and increments cnt. The edge accepting sample N-1 moves to COMPUTE, and in_ready drops in the same edge.
- COMPUTE: stage s = 0..LOG2N-1, butterfly b = 0..N/2-1, span = N>>(s+1), j = b mod span, i0 = (b/span)*2*span + j, i1 = i0+span, twiddle t = j<<s, W^t = exp(-j*2*pi*t/N).
  - Each cycle, read x0=mem[i0] and x1=mem[i1] combinationally and write both results in the same edge:
  - mem[i0] = (x0+x1)>>SCALE
  - mem[i1] = ((x0-x1)*W^t)>>SCALE
  - COMPUTE lasts exactly LOG2N*N/2 cycles (12 for N=8), then moves to UNLOAD.
- Arithmetic:
  - Sums and differences are DATA_W+1 bits.
  - t=0 bypasses the multiplier (exact). t=N/4 is implemented exactly as multiply by -j: (re,im) -> (im,-re).
  - Other t: complex multiply against the ROM twiddle; each product component is rounded half-up by adding 2^(TW_W-2) and arithmetic shifting right by TW_W-1.
  - Scaling shift truncates toward -inf.
  - Writeback to DATA_W saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Twiddle ROM holds N/2 entries: cos/-sin scaled by 2^(TW_W-1)-1, rounded to nearest, computed at elaboration.
- UNLOAD: out_valid=1, presents mem[bitrev(k)] for k=0..N-1.
  - Outputs are held stable while out_valid & !out_ready.
  - k advances only on out_valid&out_ready.
  - The handshake at k=N-1 (out_last=1) returns to LOAD: out_valid drops and in_ready rises in that same edge. No overlap of frames.
- Latency: out_valid first asserts on the edge that is LOG2N*N/2 + 1 edges after the edge accepting sample N-1 (13 edges for N=8), independent of out_ready.
- busy = (state != LOAD).
- in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.
- Reset asserted mid-frame, mid-compute or mid-unload aborts immediately to the reset values; the partial frame is discarded.

Test Plan:
- Reset/idle: rst_n=0 then 1 -> all outputs 0 during reset; in_ready=1 one edge after release; busy=0; out_valid stays 0 with no input.
- Ramp, N=8, SCALE=0: real 1..8, imag 10..17 -> the following bins, checked exactly, with out_last only on bin 7:
  - X0=36+108j
  - X2=-8+0j
  - X4=-4-4j
  - X6=0-8j
  - X1=-13.657+5.657j, checked within ±1 LSB
- Latency: stream the 8 ramp samples back-to-back with out_ready=1 -> out_valid rises exactly 13 edges after the 8th acceptance; 8 consecutive bins follow; in_ready returns on the out_last edge.
- Scaling/saturation:
  - All samples 8+0j, SCALE=1 -> X0=8, all other bins 0.
  - Same input, SCALE=0 -> X0=64.
  - All samples 2^(DATA_W-1)-1, SCALE=0 -> X0 saturates to 2^(DATA_W-1)-1.
- Backpressure: toggle out_ready randomly during UNLOAD -> out_real/out_imag/out_index are stable while stalled; bins arrive in order 0..7 with no loss or duplication; in_valid pulses during UNLOAD are not accepted.
- Reset mid-op: assert rst_n=0 during COMPUTE cycle 5 -> immediate return to LOAD values. The next full ramp frame then produces the same bins as the ramp scenario.
